// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative shift-add multiplier: data width,
// RV32M multiply operation encodings (shared with the decoder) and operand helpers.
package mul_iter_pkg;

    localparam int DATA_BUS_WIDTH = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    function automatic logic op1_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic op2_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH);
    endfunction

    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_BUS_WIDTH-1:0] magnitude(input logic [DATA_BUS_WIDTH-1:0] value,
                                                            input logic is_signed);
        if (is_signed && value[DATA_BUS_WIDTH-1])
            return (~value) + DATA_BUS_WIDTH'(1);
        return value;
    endfunction

endpackage

// File: rtl/mul_iter_if.sv
// Request/response bundle between the EX stage and the iterative multiplier.
interface mul_iter_if;
    import mul_iter_pkg::*;

    logic                      start;
    logic                      flush;
    logic [1:0]                mul_op;
    logic [DATA_BUS_WIDTH-1:0] op1;
    logic [DATA_BUS_WIDTH-1:0] op2;
    logic                      busy;
    logic                      result_valid;
    logic [DATA_BUS_WIDTH-1:0] result;

    modport master (
        output start, flush, mul_op, op1, op2,
        input  busy, result_valid, result
    );

    modport slave (
        input  start, flush, mul_op, op1, op2,
        output busy, result_valid, result
    );

endinterface

// File: rtl/mul_iter_add_row.sv
// One partial-product row: adds the multiplicand to the accumulator when enabled,
// keeping the carry. Isolated so a faster adder can be dropped in later.
module mul_add_row
    import mul_iter_pkg::*;
(
    input  logic [DATA_BUS_WIDTH-1:0] acc,
    input  logic [DATA_BUS_WIDTH-1:0] mcand,
    input  logic                      en,
    output logic [DATA_BUS_WIDTH:0]   sum
);

    logic [DATA_BUS_WIDTH:0] addend;

    assign addend = en ? {1'b0, mcand} : '0;
    assign sum    = {1'b0, acc} + addend;

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU with a
// fixed 34-cycle latency from the accepting edge to the result_valid pulse.
module mul_iter
    import mul_iter_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    mul_iter_if.slave bus
);

    localparam int W = DATA_BUS_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    state_e         state;
    logic [4:0]     count;
    logic [2*W-1:0] product;
    logic [W-1:0]   mcand;
    logic [1:0]     op;
    logic           neg;
    logic           busy;
    logic           result_valid;
    logic [W-1:0]   result;

    logic [W:0]     row_sum;
    logic [2*W-1:0] fixed_product;
    logic [W-1:0]   mag1;
    logic [W-1:0]   mag2;
    logic           neg_next;

    mul_add_row u_row (
        .acc   (product[2*W-1:W]),
        .mcand (mcand),
        .en    (product[0]),
        .sum   (row_sum)
    );

    assign mag1     = magnitude(bus.op1, op1_signed(bus.mul_op));
    assign mag2     = magnitude(bus.op2, op2_signed(bus.mul_op));
    assign neg_next = (op1_signed(bus.mul_op) & bus.op1[W-1]) ^
                      (op2_signed(bus.mul_op) & bus.op2[W-1]);

    assign fixed_product = neg ? ((~product) + (2*W)'(1)) : product;

    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
    assign bus.result       = result;

    // Flush wins over every state, including a start in IDLE and the FIX->DONE step,
    // so an aborted operation never pulses result_valid and never touches result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            count        <= '0;
            product      <= '0;
            mcand        <= '0;
            op           <= '0;
            neg          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else if (bus.flush) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    result_valid <= 1'b0;
                    if (bus.start) begin
                        op      <= bus.mul_op;
                        mcand   <= mag1;
                        product <= {{W{1'b0}}, mag2};
                        neg     <= neg_next;
                        count   <= 5'd31;
                        busy    <= 1'b1;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Carry out of the row add becomes the new top bit after the shift.
                    product <= {row_sum, product[W-1:1]};
                    count   <= count - 5'd1;
                    if (count == 5'd0)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result       <= (op == MUL_OP_MUL) ? fixed_product[W-1:0]
                                                       : fixed_product[2*W-1:W];
                    result_valid <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: randomized operations against a wide-integer
// reference product, plus latency, flush, ignored-start and async-reset scenarios.
module tb_mul_iter;
    import mul_iter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    mul_iter_if bus_if ();

    mul_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference: sign- or zero-extend both operands, multiply exactly, pick a half.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [64:0]  x;
        logic signed [64:0]  y;
        logic signed [129:0] p;
        x = (op == 2'b01 || op == 2'b10) ? {{33{a[31]}}, a} : {33'd0, a};
        y = (op == 2'b01) ? {{33{b[31]}}, b} : {33'd0, b};
        p = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in the current cycle; returns one cycle later (cycle 1).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.start  = 1'b1;
        bus_if.mul_op = op;
        bus_if.op1    = a;
        bus_if.op2    = b;
        step();
        bus_if.start  = 1'b0;
    endtask

    // Waits (bounded) for result_valid; lat is the cycle number it was seen in, -1 on timeout.
    task automatic wait_result(input int start_cyc, output logic [31:0] res, output int lat,
                               output logic busy_ok);
        busy_ok = 1'b1;
        lat     = -1;
        res     = '0;
        for (int cyc = start_cyc; cyc < start_cyc + 60; cyc++) begin
            if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
            if (bus_if.result_valid === 1'b1) begin
                res = bus_if.result;
                lat = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({bus_if.busy, bus_if.result_valid} !== 2'b00)
            $display("[TB] FAIL reset_flags: got busy/valid %b required 00", {bus_if.busy, bus_if.result_valid});
        else passed++;
        checks++;
        if (bus_if.result !== 32'h0)
            $display("[TB] FAIL reset_result: got %h required 00000000", bus_if.result);
        else passed++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        bus_if.start  = 1'b1;
        bus_if.mul_op = MUL_OP_MUL;
        bus_if.op1    = 32'd7;
        bus_if.op2    = 32'd6;
        #1;
        checks++;
        if (bus_if.busy !== 1'b0)
            $display("[TB] FAIL busy_at_start: got %b required 0", bus_if.busy);
        else passed++;
        step();
        bus_if.start = 1'b0;
        wait_result(1, res, lat, busy_ok);
        checks++;
        if (res !== 32'd42) $display("[TB] FAIL mul_7x6: got %h required %h", res, 32'd42);
        else passed++;
        checks++;
        if (lat !== 34) $display("[TB] FAIL mul_latency: got %0d required 34", lat);
        else passed++;
        checks++;
        if (busy_ok !== 1'b1) $display("[TB] FAIL busy_window: busy dropped before cycle 34");
        else passed++;
        step();
        checks++;
        if ({bus_if.busy, bus_if.result_valid} !== 2'b00)
            $display("[TB] FAIL after_done: got busy/valid %b required 00", {bus_if.busy, bus_if.result_valid});
        else passed++;
    endtask

    task automatic test_corners();
        logic [1:0]  ops  [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b10};
        logic [31:0] as   [6] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [6] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'h0000_0001, 32'hFFFF_FFFF};
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ops[i], as[i], bs[i]);
            wait_result(1, res, lat, busy_ok);
            checks++;
            if (res !== ref_mul(ops[i], as[i], bs[i]) || lat !== 34)
                $display("[TB] FAIL corner_%0d: got %h at cycle %0d required %h at cycle 34",
                         i, res, lat, ref_mul(ops[i], as[i], bs[i]));
            else passed++;
            step();
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            applyStimulus(op, a, b);
            wait_result(1, res, lat, busy_ok);
            checks++;
            if (res !== ref_mul(op, a, b) || lat !== 34 || busy_ok !== 1'b1)
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got %h at cycle %0d required %h at cycle 34",
                         i, op, a, b, res, lat, ref_mul(op, a, b));
            else passed++;
            step();
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [31:0] held;
        int          lat;
        logic        busy_ok;
        logic        saw_valid;
        saw_valid = 1'b0;
        applyStimulus(MUL_OP_MUL, 32'd1234, 32'd5678);
        for (int cyc = 1; cyc < 10; cyc++) begin
            if (bus_if.result_valid === 1'b1) saw_valid = 1'b1;
            step();
        end
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0 || saw_valid || bus_if.result_valid !== 1'b0)
            $display("[TB] FAIL flush_cycle10: got busy %b valid_seen %b required 0 0",
                     bus_if.busy, saw_valid | bus_if.result_valid);
        else passed++;
        applyStimulus(MUL_OP_MUL, 32'd3, 32'd5);
        wait_result(1, res, lat, busy_ok);
        checks++;
        if (res !== 32'd15 || lat !== 34)
            $display("[TB] FAIL after_flush_3x5: got %h at cycle %0d required 0000000f at cycle 34", res, lat);
        else passed++;
        step();

        // Flush in the FIX cycle must suppress the pulse and leave result untouched.
        held = res;
        saw_valid = 1'b0;
        applyStimulus(MUL_OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int cyc = 1; cyc < 33; cyc++) step();
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0)
            $display("[TB] FAIL flush_in_fix_busy: got %b required 0", bus_if.busy);
        else passed++;
        for (int cyc = 0; cyc < 3; cyc++) begin
            if (bus_if.result_valid === 1'b1) saw_valid = 1'b1;
            step();
        end
        checks++;
        if (saw_valid || bus_if.result !== held)
            $display("[TB] FAIL flush_in_fix_result: got valid %b result %h required 0 %h",
                     saw_valid, bus_if.result, held);
        else passed++;

        // Simultaneous start and flush in IDLE: nothing starts.
        bus_if.flush = 1'b1;
        applyStimulus(MUL_OP_MUL, 32'd9, 32'd9);
        bus_if.flush = 1'b0;
        step();
        checks++;
        if (bus_if.busy !== 1'b0)
            $display("[TB] FAIL flush_beats_start: got busy %b required 0", bus_if.busy);
        else passed++;
    endtask

    task automatic test_ignored_start();
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        applyStimulus(MUL_OP_MULHU, 32'hCAFE_F00D, 32'h8765_4321);
        for (int cyc = 1; cyc < 5; cyc++) step();
        applyStimulus(MUL_OP_MUL, 32'd11, 32'd13);
        wait_result(6, res, lat, busy_ok);
        checks++;
        if (res !== ref_mul(MUL_OP_MULHU, 32'hCAFE_F00D, 32'h8765_4321) || lat !== 34)
            $display("[TB] FAIL ignored_start: got %h at cycle %0d required %h at cycle 34",
                     res, lat, ref_mul(MUL_OP_MULHU, 32'hCAFE_F00D, 32'h8765_4321));
        else passed++;
        step();
        checks++;
        if (bus_if.busy !== 1'b0)
            $display("[TB] FAIL ignored_start_queued: got busy %b required 0", bus_if.busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        applyStimulus(MUL_OP_MULH, 32'hFFFF_FFF9, 32'd6);
        wait_result(1, res, lat, busy_ok);
        checks++;
        if (res !== ref_mul(MUL_OP_MULH, 32'hFFFF_FFF9, 32'd6) || lat !== 34)
            $display("[TB] FAIL b2b_first: got %h at cycle %0d required %h at cycle 34",
                     res, lat, ref_mul(MUL_OP_MULH, 32'hFFFF_FFF9, 32'd6));
        else passed++;
        step();
        applyStimulus(MUL_OP_MULHSU, 32'h8000_0001, 32'hF000_0000);
        wait_result(1, res, lat, busy_ok);
        checks++;
        if (res !== ref_mul(MUL_OP_MULHSU, 32'h8000_0001, 32'hF000_0000) || lat !== 34)
            $display("[TB] FAIL b2b_second: got %h at cycle %0d required %h at cycle 34",
                     res, lat, ref_mul(MUL_OP_MULHSU, 32'h8000_0001, 32'hF000_0000));
        else passed++;
        step();
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat;
        logic        busy_ok;
        applyStimulus(MUL_OP_MUL, 32'd100, 32'd200);
        for (int cyc = 1; cyc < 20; cyc++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.busy, bus_if.result_valid} !== 2'b00 || bus_if.result !== 32'h0)
            $display("[TB] FAIL async_reset: got busy/valid %b result %h required 00 00000000",
                     {bus_if.busy, bus_if.result_valid}, bus_if.result);
        else passed++;
        step();
        rst_n = 1'b1;
        step();
        applyStimulus(MUL_OP_MUL, 32'hFFFF_FFFF, 32'd2);
        wait_result(1, res, lat, busy_ok);
        checks++;
        if (res !== 32'hFFFF_FFFE || lat !== 34)
            $display("[TB] FAIL post_reset_mul: got %h at cycle %0d required fffffffe at cycle 34", res, lat);
        else passed++;
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.flush  = 1'b0;
        bus_if.mul_op = 2'b00;
        bus_if.op1    = '0;
        bus_if.op2    = '0;
        $display("[TB] starting mul_iter bench");
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_flush();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
